rsa_mont_exp: RTL and testbench
===============================

# rsa_mont_exp

Parametrised modular-exponentiation core computing `a^d mod n` for W-bit operands with right-to-left binary exponentiation over Montgomery multiplication. It is the width-generic successor of the fixed 256-bit RSA core that sits behind the RSA wrapper. Over that core it adds:
- operand capture at start;
- a busy indication;
- concurrent multiply and square;
- early termination after the highest set exponent bit;
- a one-cycle completion pulse.

## Interface
- `W`, default 256: operand/key width in bits; legal for W ≥ 4.
- `CNT_W`, default `$clog2(W+1)`: width of bit/iteration counters.

Ports:
- `i_clk`  in  1  clock, single domain.
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_start`  in  1  one-cycle request; sampled only in IDLE.
- `i_a`  in  W  base (ciphertext); caller guarantees `a < n`.
- `i_d`  in  W  exponent (private key).
- `i_n`  in  W  modulus; caller guarantees odd, `n > 1`, MSB may be 1.
- `o_busy`  out  1  high from the cycle after start is sampled until the cycle `o_finished` pulses (inclusive).
- `o_a_pow_d`  out  W  result; valid when `o_finished`=1, held until the next accepted start.
- `o_finished`  out  1  single-cycle done pulse.

## Operation
- Start accept: on `i_start`=1 in IDLE, capture `a`, `d`, `n` into internal registers. Inputs may change afterwards without effect. `i_start` while busy is ignored; there is no restart.
- Find `h` = index of the highest set bit of `d`.
- If `d`==0, go to DONE with result 1.
- States: IDLE → PREP → LAUNCH ↔ WAIT → DONE → IDLE.
- PREP (W cycles): compute `t = a·2^W mod n` by W shift-and-conditional-subtract steps: `x ← 2x`; if `x ≥ n` then `x ← x−n`. Internal width is W+1. Initialise `r = 1`.
- LAUNCH (1 cycle), iteration `i` = 0..h:
  - Always start the square `mont(t,t)`.
  - If `d[i]`=1, also start the multiply `mont(r,t)`. Both multipliers run in parallel.
- WAIT: hold until the square multiplier's done.
  - On done, `t ←` square result.
  - If `d[i]`, `r ←` multiply result (same cycle; both have identical latency).
  - If `i==h`, go to DONE; else `i++` and go to LAUNCH.
  - The square for `i==h` is still launched but its result is unused. Early termination means no iterations run for `i > h`.
- DONE (1 cycle): `o_a_pow_d ← r`, `o_finished`=1, go to IDLE.
- Result domain: `r` starts at plain 1 and `t` is in the Montgomery domain, so `mont(r,t)` yields plain `r·a^(2^i)`. No final conversion is needed. The result is fully reduced: `0 ≤ r < n`.
- Arithmetic, `mont(x,y)`:
  - Accumulator `m`, W+2 bits.
  - Per bit `k` = 0..W−1 of `x`: `m ← m + x[k]·y`; if `m` is odd, `m ← m + n`; then `m ← m >> 1`. All in one cycle.
  - Final cycle: if `m ≥ n`, `m ← m − n`.
  - No overflow occurs for `x, y < n < 2^W`.

## Timing
- Reset values: `o_a_pow_d` = 0, `o_finished` = 0, `o_busy` = 0. All state, counters and both multipliers go to idle.
- Reset mid-operation aborts immediately. The next start after reset behaves as from power-up.
- `mont_mul` latency: `o_done` pulses W+2 cycles after the cycle its `i_start` is sampled. Its result is held until its next start.
- Iteration cost: exactly W+3 cycles (LAUNCH + W+2).
- Start-to-finish latency, from the start-sample edge to the `o_finished` cycle:
  - `d` ≠ 0: `L = W + 1 + (h+1)·(W+3) + 1`.
  - `d` = 0: `L` = 2.
- `o_finished` is high for exactly one cycle.
- `o_busy` falls the cycle after `o_finished`.
- A start on the same cycle as `o_finished` is ignored.
- A start in the first IDLE cycle after DONE is accepted.

## Structure
- Package `rsa_pkg`:
  - state enum `rsa_state_e` {S_IDLE, S_PREP, S_LAUNCH, S_WAIT, S_DONE};
  - multiplier state enum {M_IDLE, M_LOOP, M_FIX};
  - default-width constant `RSA_W` = 256.
- Sub-module `mont_mul #(W)`:
  - ports `i_clk`, `i_rst`, `i_start`, `i_x`, `i_y`, `i_n`, `o_p`, `o_done`;
  - instantiated twice (`u_mul`, `u_sqr`);
  - operands latched at start.
- The PREP shifter and the highest-set-bit detect live in the top module.

## Test plan
- W=8, n=187, a=11, d=23 (h=4) → `o_a_pow_d`=88; `o_finished` at L = 9+55+1 = 65; `o_busy` high cycles 1..65.
- W=8, n=187, a=88, d=7 → 11; L = 9+33+1 = 43. Change `i_a`/`i_d`/`i_n` during busy → result unchanged.
- W=8, n=13, d=0, a=5 → result 1, L=2. Then a=0, d=5 → result 0.
- W=8, d=1, a=186, n=187 → 186 (exercises the final subtract). Pulse `i_start` mid-run → ignored, single `o_finished`.
- W=8 mid-run `i_rst` pulse:
  - all outputs go to 0;
  - a subsequent start with a=11, d=23, n=187 → 88.
- W=256 (and W=64): 200 random odd `n` with MSB set, `a < n`, random `d` → match the scoreboard `pow(a,d,n)` and latency L.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation core.
// Holds the top-level and multiplier FSM state encodings and the default width.
package rsa_pkg;

    localparam int RSA_W = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } rsa_state_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_LOOP,
        M_FIX
    } mul_state_e;

endpackage

// File: rtl/rsa_mont_exp_mont_mul.sv
// mont_mul: bit-serial Montgomery multiplier, p = x*y*2^-W mod n.
// Ports: i_clk/i_rst (async active-high), i_start (latches i_x/i_y/i_n),
//        o_p (W-bit result, held until next start), o_done (1-cycle pulse).
module mont_mul
    import rsa_pkg::*;
#(
    parameter int W     = RSA_W,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_p,
    output logic         o_done
);

    mul_state_e r_state;
    mul_state_e w_next;

    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic [W-1:0]     r_n;
    logic [W-1:0]     r_p;
    logic [W+1:0]     r_m;
    logic [CNT_W-1:0] r_k;
    logic             r_done;

    logic [W+1:0] w_add;
    logic [W+1:0] w_sum;
    logic [W+1:0] w_sumn;
    logic [W+1:0] w_step;
    logic [W+1:0] w_red;
    logic         w_last;

    // One Montgomery step: add x[k]*y, make even by adding n, halve.
    // The accumulator stays below 2n, so W+2 bits never overflow.
    assign w_add  = r_x[0] ? {2'b00, r_y} : '0;
    assign w_sum  = r_m + w_add;
    assign w_sumn = w_sum[0] ? (w_sum + {2'b00, r_n}) : w_sum;
    assign w_step = {1'b0, w_sumn[W+1:1]};

    // m < 2n after the loop, so one conditional subtract fully reduces.
    assign w_red  = (r_m >= {2'b00, r_n}) ? (r_m - {2'b00, r_n}) : r_m;

    assign w_last = (r_k == CNT_W'(W - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= M_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            M_IDLE: begin
                if (i_start) begin
                    w_next = M_LOOP;
                end
            end
            M_LOOP: begin
                if (w_last) begin
                    w_next = M_FIX;
                end
            end
            M_FIX: begin
                w_next = M_IDLE;
            end
            default: begin
                w_next = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_n    <= '0;
            r_p    <= '0;
            r_m    <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                M_IDLE: begin
                    if (i_start) begin
                        r_x <= i_x;
                        r_y <= i_y;
                        r_n <= i_n;
                        r_m <= '0;
                        r_k <= '0;
                    end
                end
                M_LOOP: begin
                    r_m <= w_step;
                    r_x <= r_x >> 1;
                    r_k <= r_k + 1'b1;
                end
                M_FIX: begin
                    r_p    <= W'(w_red);
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_p    = r_p;
    assign o_done = r_done;

endmodule

// File: rtl/rsa_mont_exp.sv
// rsa_mont_exp: a^d mod n by right-to-left binary exponentiation using two
// Montgomery multipliers (square and multiply) running side by side.
// Ports: i_clk, i_rst (async active-high), i_start (taken only when idle),
//        i_a/i_d/i_n operands captured at start, o_busy, o_a_pow_d (held
//        until next accepted start), o_finished (1-cycle pulse).
module rsa_mont_exp
    import rsa_pkg::*;
#(
    parameter int W     = RSA_W,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_n,
    output logic         o_busy,
    output logic [W-1:0] o_a_pow_d,
    output logic         o_finished
);

    rsa_state_e r_state;
    rsa_state_e w_next;

    logic [W-1:0]     r_d;
    logic [W-1:0]     r_n;
    logic [W-1:0]     r_t;
    logic [W-1:0]     r_r;
    logic [W-1:0]     r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_fin;

    logic         w_accept;
    logic         w_last;
    logic         w_prep_step;
    logic         w_sqr_start;
    logic         w_mul_start;
    logic         w_iter_done;
    logic [W:0]   w_x2;
    logic [W:0]   w_x_red;
    logic [W-1:0] w_sqr_p;
    logic [W-1:0] w_mul_p;
    logic         w_sqr_done;
    logic         w_mul_done;

    // r_busy still covers the o_finished cycle, so a start there is ignored.
    assign w_accept = (r_state == S_IDLE) && i_start && !r_busy;

    // r_d is consumed LSB first; the current bit is the highest set bit
    // once nothing above it remains, which ends the loop early.
    assign w_last = ~|r_d[W-1:1];

    // Domain conversion step: t <- 2t mod n.
    assign w_x2    = {r_t, 1'b0};
    assign w_x_red = (w_x2 >= {1'b0, r_n}) ? (w_x2 - {1'b0, r_n}) : w_x2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_prep_step = 1'b0;
        w_sqr_start = 1'b0;
        w_mul_start = 1'b0;
        w_iter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                // Final PREP cycle only hands over; it does no shift.
                if (r_d == '0) begin
                    w_next = S_DONE;
                end else if (r_cnt == CNT_W'(W)) begin
                    w_next = S_LAUNCH;
                end else begin
                    w_prep_step = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_sqr_start = 1'b1;
                w_mul_start = r_d[0];
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (w_sqr_done && (w_mul_done || !r_d[0])) begin
                    w_iter_done = 1'b1;
                    w_next      = w_last ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d    <= '0;
            r_n    <= '0;
            r_t    <= '0;
            r_r    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_fin  <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            if (w_accept) begin
                r_t    <= i_a;
                r_d    <= i_d;
                r_n    <= i_n;
                r_r    <= W'(1);
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (r_fin) begin
                r_busy <= 1'b0;
            end
            if (w_prep_step) begin
                r_t   <= W'(w_x_red);
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_iter_done) begin
                r_t <= w_sqr_p;
                if (r_d[0]) begin
                    r_r <= w_mul_p;
                end
                r_d <= r_d >> 1;
            end
            if (r_state == S_DONE) begin
                r_res <= r_r;
                r_fin <= 1'b1;
            end
        end
    end

    // r is plain and t is Montgomery-domain, so mont(r,t) stays plain.
    mont_mul #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_mul_start),
        .i_x     (r_r),
        .i_y     (r_t),
        .i_n     (r_n),
        .o_p     (w_mul_p),
        .o_done  (w_mul_done)
    );

    mont_mul #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_sqr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_sqr_start),
        .i_x     (r_t),
        .i_y     (r_t),
        .i_n     (r_n),
        .o_p     (w_sqr_p),
        .o_done  (w_sqr_done)
    );

    assign o_busy     = r_busy;
    assign o_a_pow_d  = r_res;
    assign o_finished = r_fin;

endmodule

// File: tb/tb_rsa_mont_exp.sv
// Self-checking bench for rsa_mont_exp at W=8 (directed) and W=64 (random).
// Expected results and latencies come from a software modpow scoreboard.
module tb_rsa_mont_exp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        st8 = 1'b0;
    logic [7:0]  a8  = '0;
    logic [7:0]  d8  = '0;
    logic [7:0]  n8  = 8'd1;
    logic        busy8;
    logic [7:0]  res8;
    logic        fin8;

    logic        st64 = 1'b0;
    logic [63:0] a64  = '0;
    logic [63:0] d64  = '0;
    logic [63:0] n64  = 64'd1;
    logic        busy64;
    logic [63:0] res64;
    logic        fin64;

    rsa_mont_exp #(.W(8)) u_dut8 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (st8),
        .i_a        (a8),
        .i_d        (d8),
        .i_n        (n8),
        .o_busy     (busy8),
        .o_a_pow_d  (res8),
        .o_finished (fin8)
    );

    rsa_mont_exp #(.W(64)) u_dut64 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (st64),
        .i_a        (a64),
        .i_d        (d64),
        .i_n        (n64),
        .o_busy     (busy64),
        .o_a_pow_d  (res64),
        .o_finished (fin64)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int t0 = 0;
    logic [63:0] q_val[$];
    int          q_lat[$];

    function automatic logic [63:0] modpow(input logic [63:0] a,
                                           input logic [63:0] d,
                                           input logic [63:0] n);
        logic [127:0] r;
        logic [127:0] b;
        r = 128'd1 % {64'd0, n};
        b = {64'd0, a} % {64'd0, n};
        for (int i = 0; i < 64; i++) begin
            if (d[i]) r = (r * b) % {64'd0, n};
            b = (b * b) % {64'd0, n};
        end
        return r[63:0];
    endfunction

    function automatic int lat(input logic [63:0] d, input int w);
        int h;
        if (d == 64'd0) return 2;
        h = 0;
        for (int i = 0; i < 64; i++) if (d[i]) h = i;
        return w + 1 + (h + 1) * (w + 3) + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go8(input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] n);
        @(negedge clk);
        a8  = a[7:0];
        d8  = d[7:0];
        n8  = n[7:0];
        st8 = 1'b1;
        q_val.push_back(modpow(a, d, n));
        q_lat.push_back(lat(d, 8));
        @(negedge clk);
        st8 = 1'b0;
        t0  = cyc;
    endtask

    task automatic go64(input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] n);
        @(negedge clk);
        a64  = a;
        d64  = d;
        n64  = n;
        st64 = 1'b1;
        q_val.push_back(modpow(a, d, n));
        q_lat.push_back(lat(d, 64));
        @(negedge clk);
        st64 = 1'b0;
        t0   = cyc;
    endtask

    task automatic wait_fin(input bit big, input string tag, input bit chain);
        int          cnt;
        int          bound;
        bit          bad;
        logic [63:0] ev;
        int          el;
        logic        f;
        logic        b;
        cnt   = 0;
        bad   = 1'b0;
        bound = q_lat[0] + 20;
        ev    = q_val.pop_front();
        el    = q_lat.pop_front();
        f     = big ? fin64 : fin8;
        while (!f && cnt < bound) begin
            b = big ? busy64 : busy8;
            if (!b) bad = 1'b1;
            @(negedge clk);
            cnt++;
            f = big ? fin64 : fin8;
        end
        b = big ? busy64 : busy8;
        chk({tag, "_done"}, {63'd0, f}, 64'd1);
        chk({tag, "_busy"}, {63'd0, b && !bad}, 64'd1);
        chk({tag, "_res"}, big ? res64 : {56'd0, res8}, ev);
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(el));
        if (!chain) begin
            @(negedge clk);
            f = big ? fin64 : fin8;
            b = big ? busy64 : busy8;
            chk({tag, "_pulse"}, {63'd0, f}, 64'd0);
            chk({tag, "_busyfall"}, {63'd0, b}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rn;
        logic [63:0] ra;
        logic [63:0] rd;
        logic [63:0] dummy;
        int          extra;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_res", {56'd0, res8}, 64'd0);
        chk("rst_fin", {63'd0, fin8}, 64'd0);
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_busy64", {63'd0, busy64}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        go8(11, 23, 187);
        wait_fin(1'b0, "p1", 1'b0);

        go8(88, 7, 187);
        a8 = 8'd5;
        d8 = 8'hff;
        n8 = 8'd13;
        wait_fin(1'b0, "p2", 1'b0);

        go8(5, 0, 13);
        wait_fin(1'b0, "p3_d0", 1'b0);
        go8(0, 5, 13);
        wait_fin(1'b0, "p4_a0", 1'b0);

        go8(186, 1, 187);
        repeat (4) @(negedge clk);
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        wait_fin(1'b0, "p5", 1'b0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (fin8) extra++;
        end
        chk("p5_single", 64'(extra), 64'd0);

        go8(11, 23, 187);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_res", {56'd0, res8}, 64'd0);
        chk("mrst_fin", {63'd0, fin8}, 64'd0);
        chk("mrst_busy", {63'd0, busy8}, 64'd0);
        rst = 1'b0;
        dummy = q_val.pop_front();
        extra = q_lat.pop_front();
        go8(11, 23, 187);
        wait_fin(1'b0, "p6", 1'b0);

        go8(5, 3, 13);
        wait_fin(1'b0, "p7", 1'b1);
        a8  = 8'd2;
        d8  = 8'd10;
        n8  = 8'd13;
        st8 = 1'b1;
        q_val.push_back(modpow(2, 10, 13));
        q_lat.push_back(lat(10, 8));
        @(negedge clk);
        chk("p7_ign_busy", {63'd0, busy8}, 64'd0);
        chk("p7_ign_fin", {63'd0, fin8}, 64'd0);
        @(negedge clk);
        st8 = 1'b0;
        t0  = cyc;
        wait_fin(1'b0, "p8", 1'b0);

        for (int k = 0; k < 18; k++) begin
            rn     = {$urandom, $urandom};
            rn[63] = 1'b1;
            rn[0]  = 1'b1;
            ra     = {$urandom, $urandom} % rn;
            if (k < 16) begin
                rd = 64'($urandom_range(1, 65535));
            end else begin
                rd     = {$urandom, $urandom};
                rd[63] = 1'b1;
            end
            go64(ra, rd, rn);
            wait_fin(1'b1, $sformatf("r%0d", k), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
